pc_fetch_unit: RTL and testbench

- Program-counter and fetch-address generator for the RIPTIDE-II core; sits directly upstream of the instruction decoder.
- Drives the 13-bit program-cache address and consumes the decoder's registered control-flow outputs (JMP/XEC/NZT/CALL/RET, I field, long_I) plus the execute-stage ALU result.
- Owns the hardware call stack, the XEC single-instruction detour and wrong-path flush generation.

---
 rtl/pc_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- program counter and fetch-address generator.
//
// Produces the registered program-cache address, follows the decoder's
// control-flow outputs for the instruction at ex_pc, owns the call stack,
// runs the XEC one-instruction detour and flushes wrong-path fetches.
//
// Ports:
//   clk, n_RST         clock, async active-low reset
//   hazard             stall from hazard detection
//   p_cache_miss       fetch data invalid, stall
//   PC_JMP/XEC/NZT/CALL/RET, PC_I_field, long_I
//                      decoded controls for the instruction at ex_pc
//   alu_result         execute-stage result (NZT condition, XEC offset)
//   p_address          fetch address (registered)
//   flush              squash the instruction entering decode
//   stack_empty        call stack holds nothing
//   stack_overflow     sticky, push while full
module pc_fetch_unit #(
   parameter int STACK_DEPTH  = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        n_RST,
   input  logic        hazard,
   input  logic        p_cache_miss,
   input  logic        PC_JMP,
   input  logic        PC_XEC,
   input  logic        PC_NZT,
   input  logic        PC_CALL,
   input  logic        PC_RET,
   input  logic [12:0] PC_I_field,
   input  logic        long_I,
   input  logic [7:0]  alu_result,
   output logic [12:0] p_address,
   output logic        flush,
   output logic        stack_empty,
   output logic        stack_overflow
);
   localparam int SPW = $clog2(STACK_DEPTH);
   localparam int CW  = $clog2(FLUSH_CYCLES + 1);
   localparam logic [SPW:0]  STK_FULL = (SPW+1)'(STACK_DEPTH);
   localparam logic [CW-1:0] FC       = CW'(FLUSH_CYCLES);

   typedef enum logic [1:0] {RUN, XEC1, XEC2} state_t;
   state_t state, state_nxt;

   logic [FLUSH_CYCLES-1:0][12:0] addr_pipe;
   logic [12:0]    ex_pc, seq, target, ret_addr;
   logic [CW-1:0]  fcnt, xcnt;
   logic [SPW-1:0] sp;
   logic [SPW:0]   cnt;
   logic [12:0]    stack_mem [STACK_DEPTH];
   logic           advance, ev_ok, take, push, pop, xec_ev, ld_ret;

   assign advance     = ~hazard & ~p_cache_miss;
   assign ex_pc       = addr_pipe[FLUSH_CYCLES-1];
   assign seq         = ex_pc + 13'd1;
   assign flush       = (fcnt != '0);
   assign stack_empty = (cnt == '0);
   // controls of a wrong-path instruction are never acted on
   assign ev_ok       = advance & (fcnt == '0);

   // control event decode, RET highest priority
   always_comb begin
      take   = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      xec_ev = 1'b0;
      target = seq;
      if (ev_ok) begin
         if (PC_RET) begin
            take   = 1'b1;
            pop    = 1'b1;
            target = stack_mem[sp - SPW'(1)];
         end else if (PC_CALL) begin
            // decoder also raises NZT for CALL; CALL wins outright
            take   = 1'b1;
            push   = 1'b1;
            target = {ex_pc[12:8], PC_I_field[7:0]};
         end else if (PC_JMP) begin
            take   = 1'b1;
            target = PC_I_field;
         end else if (PC_XEC) begin
            take   = 1'b1;
            xec_ev = 1'b1;
            target = long_I ? {ex_pc[12:8], alu_result}
                            : {ex_pc[12:5], alu_result[4:0]};
         end else if (PC_NZT && (|alu_result)) begin
            take   = 1'b1;
            target = long_I ? {ex_pc[12:8], PC_I_field[7:0]}
                            : {ex_pc[12:5], PC_I_field[4:0]};
         end
      end
   end

   // XEC detour: XEC1 fetches the return address right behind the target,
   // XEC2 covers the target's trip to resolution so a nested XEC keeps the
   // original return address.
   always_comb begin
      state_nxt = state;
      ld_ret    = 1'b0;
      case (state)
         RUN:  if (xec_ev) state_nxt = XEC1;
         XEC1: if (advance) begin
                  ld_ret    = 1'b1;
                  state_nxt = XEC2;
               end
         XEC2: if (xec_ev)
                  state_nxt = XEC1;
               else if (take || (advance && xcnt == CW'(1)))
                  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge n_RST) begin
      if (!n_RST) begin
         state          <= RUN;
         p_address      <= '0;
         addr_pipe      <= '0;
         fcnt           <= '0;
         xcnt           <= '0;
         ret_addr       <= '0;
         sp             <= '0;
         cnt            <= '0;
         stack_overflow <= 1'b0;
      end else if (advance) begin
         state        <= state_nxt;
         addr_pipe[0] <= p_address;
         for (int i = 1; i < FLUSH_CYCLES; i++)
            addr_pipe[i] <= addr_pipe[i-1];

         if (ld_ret)    p_address <= ret_addr;
         else if (take) p_address <= target;
         else           p_address <= p_address + 13'd1;

         // the target fetched during XEC1 must not be flushed: no reload there
         if (take && !ld_ret)  fcnt <= FC;
         else if (fcnt != '0)  fcnt <= fcnt - CW'(1);

         if (ld_ret)           xcnt <= FC;
         else if (xcnt != '0)  xcnt <= xcnt - CW'(1);

         if (xec_ev && state == RUN) ret_addr <= seq;

         if (push) begin
            sp <= sp + SPW'(1);
            // full: pointer wrap lands on the oldest entry, which is overwritten
            if (cnt == STK_FULL) stack_overflow <= 1'b1;
            else                 cnt <= cnt + (SPW+1)'(1);
         end else if (pop) begin
            sp <= sp - SPW'(1);
            if (cnt != '0) cnt <= cnt - (SPW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance && push) stack_mem[sp] <= seq;
   end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit -- directed bench for pc_fetch_unit with a reference
// model (fetch queue, bounded LIFO, detour bookkeeping) compared on every
// falling edge, plus hand-computed expectations along the way.
module tb_pc_fetch_unit;
   localparam int FC    = 2;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        n_RST;
   logic        hazard, p_cache_miss;
   logic        PC_JMP, PC_XEC, PC_NZT, PC_CALL, PC_RET;
   logic [12:0] PC_I_field;
   logic        long_I;
   logic [7:0]  alu_result;
   logic [12:0] p_address;
   logic        flush, stack_empty, stack_overflow;

   pc_fetch_unit #(.STACK_DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .n_RST(n_RST), .hazard(hazard), .p_cache_miss(p_cache_miss),
      .PC_JMP(PC_JMP), .PC_XEC(PC_XEC), .PC_NZT(PC_NZT), .PC_CALL(PC_CALL),
      .PC_RET(PC_RET), .PC_I_field(PC_I_field), .long_I(long_I),
      .alu_result(alu_result), .p_address(p_address), .flush(flush),
      .stack_empty(stack_empty), .stack_overflow(stack_overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_pc       = 0;
   int m_pipe[$]  = '{0, 0};   // in-flight fetch addresses, [0] is at resolution
   int m_fl       = 0;         // wrong-path instructions still to squash
   int m_stk[$];               // back = top of stack
   bit m_ovf      = 1'b0;
   int m_ret      = -1;        // detour return address, -1 when no detour
   bit m_due      = 1'b0;      // next advance fetches m_ret
   int m_guard    = 0;         // advances until the detour target resolves

   task automatic m_reset();
      m_pc = 0;
      m_pipe.delete();
      for (int i = 0; i < FC; i++) m_pipe.push_back(0);
      m_fl = 0; m_stk.delete(); m_ovf = 1'b0;
      m_ret = -1; m_due = 1'b0; m_guard = 0;
   endtask

   task automatic m_step();
      int ex, sq, nxt, tgt, I, alu;
      bit tk, is_xec;
      ex  = m_pipe[0];
      sq  = (ex + 1) % 8192;
      nxt = (m_pc + 1) % 8192;
      I   = int'(PC_I_field);
      alu = int'(alu_result);
      tk = 1'b0; is_xec = 1'b0; tgt = 0;
      if (m_due) begin
         nxt = m_ret; m_due = 1'b0; m_guard = FC;
      end else begin
         if (m_fl == 0) begin
            if (PC_RET) begin
               tk = 1'b1;
               if (m_stk.size() > 0) tgt = m_stk.pop_back();
            end else if (PC_CALL) begin
               tk = 1'b1;
               tgt = (ex & 'h1F00) | (I & 'hFF);
               if (m_stk.size() == DEPTH) begin
                  void'(m_stk.pop_front());
                  m_ovf = 1'b1;
               end
               m_stk.push_back(sq);
            end else if (PC_JMP) begin
               tk = 1'b1; tgt = I;
            end else if (PC_XEC) begin
               tk = 1'b1; is_xec = 1'b1;
               tgt = long_I ? ((ex & 'h1F00) | alu) : ((ex & 'h1FE0) | (alu & 'h1F));
            end else if (PC_NZT && alu != 0) begin
               tk = 1'b1;
               tgt = long_I ? ((ex & 'h1F00) | (I & 'hFF)) : ((ex & 'h1FE0) | (I & 'h1F));
            end
         end
         if (tk) begin
            nxt = tgt;
            if (is_xec) begin
               if (m_ret < 0) m_ret = sq;
               m_due = 1'b1;
            end else begin
               m_ret = -1;
            end
            m_guard = 0;
         end else if (m_guard > 0) begin
            m_guard--;
            if (m_guard == 0) m_ret = -1;
         end
      end
      if (tk) m_fl = FC;
      else if (m_fl > 0) m_fl--;
      m_pipe.push_back(m_pc);
      void'(m_pipe.pop_front());
      m_pc = nxt;
   endtask

   always @(posedge clk or negedge n_RST) begin
      if (!n_RST) m_reset();
      else if (!hazard && !p_cache_miss) m_step();
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         chk("p_address", int'(p_address), m_pc);
         chk("flush", int'(flush), int'(m_fl != 0));
         chk("stack_empty", int'(stack_empty), int'(m_stk.size() == 0));
         chk("stack_overflow", int'(stack_overflow), int'(m_ovf));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      PC_JMP = 0; PC_XEC = 0; PC_NZT = 0; PC_CALL = 0; PC_RET = 0;
      PC_I_field = '0; long_I = 0; alu_result = '0;
   endtask

   task automatic wait_fl0();
      for (int i = 0; i < 16 && flush; i++) tick();
      chk("flush_settle", int'(flush), 0);
   endtask

   task automatic goto_ex(input int a);
      int n = 0;
      while (!(m_pipe[0] == a && m_fl == 0) && n < 9000) begin
         tick();
         n++;
      end
      chk("goto_ex_reach", m_pipe[0], a);
   endtask

   task automatic jump_to(input int a);
      wait_fl0();
      PC_JMP = 1; PC_I_field = 13'(a);
      tick();
      idle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      n_RST = 0; hazard = 0; p_cache_miss = 0;
      idle();
      tick();
      tick();
      chk_on = 1'b1;
      chk("rst_p", int'(p_address), 0);
      chk("rst_flush", int'(flush), 0);
      chk("rst_empty", int'(stack_empty), 1);
      chk("rst_ovf", int'(stack_overflow), 0);

      // sequential fetch after reset
      n_RST = 1;
      for (int i = 0; i < 5; i++) begin
         chk("seq_p", int'(p_address), i);
         chk("seq_flush", int'(flush), 0);
         chk("seq_empty", int'(stack_empty), 1);
         tick();
      end

      // JMP
      goto_ex('h0010);
      PC_JMP = 1; PC_I_field = 13'h1234;
      tick(); idle();
      chk("jmp_p0", int'(p_address), 'h1234); chk("jmp_fl0", int'(flush), 1);
      tick();
      chk("jmp_p1", int'(p_address), 'h1235); chk("jmp_fl1", int'(flush), 1);
      tick();
      chk("jmp_p2", int'(p_address), 'h1236); chk("jmp_fl2", int'(flush), 0);

      // NZT not taken, then taken (short form)
      jump_to('h0A40); goto_ex('h0A47);
      PC_NZT = 1; long_I = 0; PC_I_field = 13'h0005; alu_result = 8'd0;
      tick(); idle();
      chk("nzt0_p", int'(p_address), 'h0A4A); chk("nzt0_fl", int'(flush), 0);
      jump_to('h0A40); goto_ex('h0A47);
      PC_NZT = 1; long_I = 0; PC_I_field = 13'h0005; alu_result = 8'd3;
      tick(); idle();
      chk("nzt1_p", int'(p_address), 'h0A45); chk("nzt1_fl", int'(flush), 1);

      // CALL (with NZT also raised) then RET
      jump_to('h0300); goto_ex('h0310);
      PC_CALL = 1; PC_NZT = 1; PC_I_field = 13'h1F80; alu_result = 8'd1;
      tick(); idle();
      chk("call_p", int'(p_address), 'h0380); chk("call_empty", int'(stack_empty), 0);
      wait_fl0();
      PC_RET = 1;
      tick(); idle();
      chk("ret_p", int'(p_address), 'h0311); chk("ret_empty", int'(stack_empty), 1);

      // XEC long form
      jump_to('h0500); goto_ex('h0500);
      PC_XEC = 1; long_I = 1; alu_result = 8'h42;
      tick(); idle();
      chk("xec_p0", int'(p_address), 'h0542);
      tick(); chk("xec_p1", int'(p_address), 'h0501);
      tick(); chk("xec_p2", int'(p_address), 'h0502); chk("xec_tgt_fl", int'(flush), 0);
      tick(); chk("xec_p3", int'(p_address), 'h0503); chk("xec_ret_fl", int'(flush), 0);

      // nested XEC from the target keeps the first return address
      jump_to('h0600); goto_ex('h0600);
      PC_XEC = 1; long_I = 1; alu_result = 8'h42;
      tick(); idle();
      chk("nest_p0", int'(p_address), 'h0642);
      tick(); chk("nest_p1", int'(p_address), 'h0601);
      tick(); chk("nest_p2", int'(p_address), 'h0602);
      PC_XEC = 1; long_I = 1; alu_result = 8'h50;
      tick(); idle();
      chk("nest_p3", int'(p_address), 'h0650);
      tick(); chk("nest_p4", int'(p_address), 'h0601);
      tick(); chk("nest_p5", int'(p_address), 'h0602);
      tick(); chk("nest_p6", int'(p_address), 'h0603); chk("nest_fl", int'(flush), 0);

      // address wrap
      jump_to('h1FFE);
      chk("wrap_p0", int'(p_address), 'h1FFE);
      tick(); chk("wrap_p1", int'(p_address), 'h1FFF);
      tick(); chk("wrap_p2", int'(p_address), 'h0000);

      // hazard / cache miss freeze mid-flush
      jump_to('h0100);
      chk("hz_p0", int'(p_address), 'h0100); chk("hz_fl0", int'(flush), 1);
      hazard = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hz_hold_p", int'(p_address), 'h0100); chk("hz_hold_fl", int'(flush), 1);
      end
      hazard = 0; p_cache_miss = 1;
      tick(); chk("miss_hold_p", int'(p_address), 'h0100);
      p_cache_miss = 0;
      tick(); chk("hz_p1", int'(p_address), 'h0101); chk("hz_fl1", int'(flush), 1);
      tick(); chk("hz_p2", int'(p_address), 'h0102); chk("hz_fl2", int'(flush), 0);
      hazard = 1; PC_JMP = 1; PC_I_field = 13'h1555;
      tick(); chk("hz_ignore_p", int'(p_address), 'h0102);
      hazard = 0; idle();
      tick(); chk("hz_resume_p", int'(p_address), 'h0103);

      // 17 calls overflow a 16-entry stack
      wait_fl0();
      PC_CALL = 1; PC_I_field = 13'h0000;
      for (int i = 0; i < 48; i++) tick();
      chk("ovf_pre", int'(stack_overflow), 0); chk("ovf_empty", int'(stack_empty), 0);
      tick();
      chk("ovf_set", int'(stack_overflow), 1);
      idle();
      for (int i = 0; i < 3; i++) tick();
      chk("ovf_sticky", int'(stack_overflow), 1);
      PC_RET = 1;
      tick(); idle();
      chk("ovf_sticky_pop", int'(stack_overflow), 1);

      // reset mid-XEC
      jump_to('h0700); goto_ex('h0700);
      PC_XEC = 1; long_I = 1; alu_result = 8'h11;
      tick(); idle();
      chk("rxec_p", int'(p_address), 'h0711);
      #2 n_RST = 0;
      #1;
      chk("rxec_rst_p", int'(p_address), 0);
      chk("rxec_rst_fl", int'(flush), 0);
      chk("rxec_rst_ovf", int'(stack_overflow), 0);
      chk("rxec_rst_empty", int'(stack_empty), 1);
      @(negedge clk); #1 n_RST = 1;
      tick();
      chk("rxec_run_p", int'(p_address), 1);
      tick();
      chk("rxec_run_p2", int'(p_address), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
